// File: rtl/present_pkg.sv
// Shared constants, S-box and state encoding for the PRESENT-80 key schedule
// and the cipher datapath that consumes its round keys.
package present_pkg;

  localparam int KEY_SIZE   = 80;
  localparam int RK_SIZE    = 64;
  localparam int NUM_ROUNDS = 32;
  localparam int IDX_W      = 5;

  // Entry n sits in bits [4n+3:4n]: S(0)=C, S(1)=5, ... S(15)=2.
  localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/present_key_round.sv
// One PRESENT-80 key-register update: rotate, S-box on the top nibble, and
// round-counter XOR. Purely combinational so the cipher datapath can share it.
module present_key_round
  import present_pkg::*;
(
  input  logic [KEY_SIZE-1:0] k,
  input  logic [IDX_W-1:0]    i,
  output logic [KEY_SIZE-1:0] k_next
);

  always_comb begin
    k_next          = {k[18:0], k[79:19]};
    k_next[79:76]   = sbox(k_next[79:76]);
    k_next[19:15]   = k_next[19:15] ^ i;
  end

endmodule

// File: rtl/present_key_sched.sv
// PRESENT-80 key schedule: expands an accepted cipher key into 32 stored
// round keys, one per cycle, and serves registered reads once complete.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no key loaded; accepts a key handshake
//   ST_EXPAND | generating K2..K32, one slot per cycle; key_valid ignored
//   ST_READY  | all round keys valid; reads served, new key re-keys
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_SIZE   = present_pkg::KEY_SIZE,
  parameter int RK_SIZE    = present_pkg::RK_SIZE,
  parameter int NUM_ROUNDS = present_pkg::NUM_ROUNDS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_SIZE-1:0] key_in,
  output logic                done,
  input  logic                rd_en,
  input  logic [4:0]          rd_idx,
  output logic                rd_valid,
  output logic [RK_SIZE-1:0]  rd_key
);

  state_e              state_q, state_d;
  logic [KEY_SIZE-1:0] k_q, k_d, k_next;
  logic [4:0]          i_q, i_d;
  logic                rd_valid_q, rd_valid_d;
  logic [RK_SIZE-1:0]  rd_key_q, rd_key_d;

  logic [RK_SIZE-1:0]  mem_q [NUM_ROUNDS];
  logic                wr_en;
  logic [4:0]          wr_idx;
  logic [RK_SIZE-1:0]  wr_data;
  logic                key_hs;

  present_key_round u_round (
    .k      (k_q),
    .i      (i_q),
    .k_next (k_next)
  );

  assign key_ready = (state_q != ST_EXPAND);
  assign done      = (state_q == ST_READY);
  assign key_hs    = key_valid && key_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    wr_en   = 1'b0;
    wr_idx  = i_q;
    wr_data = k_next[KEY_SIZE-1 -: RK_SIZE];

    case (state_q)
      ST_IDLE, ST_READY: begin
        if (key_hs) begin
          state_d = ST_EXPAND;
          k_d     = key_in;
          i_d     = 5'd1;
          wr_en   = 1'b1;
          wr_idx  = 5'd0;
          wr_data = key_in[KEY_SIZE-1 -: RK_SIZE];
        end
      end
      ST_EXPAND: begin
        k_d   = k_next;
        wr_en = 1'b1;
        // Counter parks at the last round value instead of wrapping to 0.
        if (i_q == 5'(NUM_ROUNDS - 1)) begin
          state_d = ST_READY;
        end else begin
          i_d = i_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage reads the pre-edge array, so a read coinciding with a re-key
  // handshake still returns the old key set.
  always_comb begin
    rd_valid_d = rd_en && done;
    rd_key_d   = rd_valid_d ? mem_q[rd_idx] : rd_key_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      i_q        <= '0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      i_q        <= i_d;
      rd_valid_q <= rd_valid_d;
      rd_key_q   <= rd_key_d;
    end
  end

  // Round-key storage is deliberately not reset; done gates its visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_key   = rd_key_q;

endmodule

// File: tb/tb_present_key_sched.sv
// Self-checking bench for present_key_sched: reference key-schedule model,
// read scoreboard, done/key_ready timing, re-key and mid-expansion reset.
module tb_present_key_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [79:0] key_in;
  logic        done;
  logic        rd_en;
  logic [4:0]  rd_idx;
  logic        rd_valid;
  logic [63:0] rd_key;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [63:0] key;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_rk [32];
  logic [63:0] last_key;

  present_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .done      (done),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_key    (rd_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [79:0] ref_round(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r = (k << 61) | (k >> 19);
    r[79:76] = ref_sbox(r[79:76]);
    r[19:15] = r[19:15] ^ i;
    return r;
  endfunction

  task automatic fill(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    exp_rk[0] = key[79:16];
    for (int r = 1; r < 32; r++) begin
      k = ref_round(k, 5'(r));
      exp_rk[r] = k[79:16];
    end
  endtask

  task automatic push_exp(input logic v, input logic [63:0] key);
    exp_t e;
    e.v = v;
    e.key = v ? key : last_key;
    if (v) last_key = key;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 64'(rd_valid), 64'(e.v));
      check({tag, "_key"}, rd_key, e.key);
    end
  endtask

  task automatic read_one(input string tag, input logic [4:0] idx, input logic v,
                          input logic [63:0] key);
    @(negedge clk);
    rd_en  = 1'b1;
    rd_idx = idx;
    push_exp(v, key);
    @(negedge clk);
    rd_en = 1'b0;
    pop_cmp(tag);
  endtask

  // Handshake, then check done/key_ready cycle by cycle through T+32.
  task automatic run_key(input logic [79:0] key, input bit pulse);
    @(negedge clk);
    key_in    = key;
    key_valid = 1'b1;
    check("ready_at_hs", 64'(key_ready), 64'd1);
    fill(key);
    @(negedge clk);
    key_valid = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      check("done_in_expand", 64'(done), 64'd0);
      check("ready_in_expand", 64'(key_ready), 64'd0);
      if (pulse && c == 10) begin
        key_valid = 1'b1;
        key_in    = ~key;
      end
      @(negedge clk);
      key_valid = 1'b0;
    end
    check("done_at_T32", 64'(done), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    logic [79:0] key_a, key_b;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rd_en     = 1'b0;
    rd_idx    = '0;
    last_key  = '0;
    key_a = {$urandom(), $urandom(), 16'($urandom())};
    key_b = {$urandom(), $urandom(), 16'($urandom())};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(key_ready), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_key", rd_key, 64'd0);

    read_one("gated_idle", 5'd0, 1'b0, 64'd0);

    // Zero key: known vectors
    run_key(80'd0, 1'b0);
    read_one("zero_k1", 5'd0, 1'b1, 64'h0000000000000000);
    read_one("zero_k2", 5'd1, 1'b1, 64'hC000000000000000);
    read_one("zero_k3", 5'd2, 1'b1, 64'h5000180000000001);

    // Random key with ignored key_valid pulse, back-to-back reads of all slots
    run_key(key_a, 1'b1);
    for (int j = 0; j <= 32; j++) begin
      @(negedge clk);
      if (j > 0) pop_cmp("sweep_a");
      if (j < 32) begin
        rd_en  = 1'b1;
        rd_idx = 5'(j);
        push_exp(1'b1, exp_rk[j]);
      end else begin
        rd_en = 1'b0;
      end
    end

    // Re-key with a simultaneous read: read returns old K1
    @(negedge clk);
    rd_en     = 1'b1;
    rd_idx    = 5'd0;
    key_valid = 1'b1;
    key_in    = key_b;
    push_exp(1'b1, exp_rk[0]);
    @(negedge clk);
    rd_en     = 1'b0;
    key_valid = 1'b0;
    pop_cmp("rekey_old_k1");
    check("rekey_done_drop", 64'(done), 64'd0);
    fill(key_b);
    wait_done("rekey_done_wait");
    read_one("rekey_new_k1", 5'd0, 1'b1, key_b[79:16]);
    read_one("rekey_new_k32", 5'd31, 1'b1, exp_rk[31]);

    // Mid-expansion: gated read holds rd_key, then reset at T+15 aborts
    @(negedge clk);
    key_in    = key_a;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    read_one("gated_expand", 5'd3, 1'b0, 64'd0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    last_key = '0;
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_rd_key", rd_key, 64'd0);
    check("midrst_rd_valid", 64'(rd_valid), 64'd0);
    check("midrst_ready", 64'(key_ready), 64'd1);
    repeat (35) @(negedge clk);
    check("midrst_aborted", 64'(done), 64'd0);

    run_key(80'd0, 1'b0);
    read_one("after_rst_k3", 5'd2, 1'b1, 64'h5000180000000001);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/present_key_sched.md
PRESENT_KEY_SCHED -- requirements
Module: present_key_sched

Interface
REQ-001 Parameter KEY_SIZE, default 80, width of the PRESENT cipher key.
REQ-002 Parameter RK_SIZE, default 64, width of one round key.
REQ-003 Parameter NUM_ROUNDS, default 32, number of round keys stored (K1..K32).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 key_valid  input  1  key_in holds a new cipher key.
REQ-007 key_ready  output  1  block accepts a key this cycle.
REQ-008 key_in  input  KEY_SIZE  cipher key, bit 79 = MSB.
REQ-009 done  output  1  all NUM_ROUNDS round keys are valid in storage.
REQ-010 rd_en  input  1  round-key read request.
REQ-011 rd_idx  input  5  round-key index; 0 selects K1, 31 selects K32.
REQ-012 rd_valid  output  1  rd_key holds valid data for the previous-cycle request.
REQ-013 rd_key  output  RK_SIZE  registered round-key read data.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXPAND, READY.
REQ-015 A key handshake SHALL occur on a cycle where key_valid and key_ready are both 1.
REQ-016 key_ready SHALL be 1 in IDLE and READY, and 0 in EXPAND.
REQ-017 On a handshake, the block SHALL load k = key_in, write K1 = key_in[79:16] to slot 0, set round counter i = 1, and enter EXPAND.
REQ-018 In EXPAND, each cycle the block SHALL update k as follows, in order:
- rotate left by 61: k = {k[18:0], k[79:19]};
- k[79:76] = SBOX(k[79:76]);
- k[19:15] ^= i (5 bits).
REQ-019 In EXPAND, each cycle the block SHALL write the updated k[79:16] to slot i, then increment i.
REQ-020 After the cycle that writes slot 31, the FSM SHALL enter READY.
REQ-021 done SHALL be 1 exactly while in READY, first asserting 32 cycles after the handshake edge.
REQ-022 A handshake in READY SHALL re-key: done drops the following cycle and the expansion restarts from REQ-017.
REQ-023 key_valid in EXPAND SHALL be ignored (not queued).
REQ-024 rd_key and rd_valid SHALL be registered with 1-cycle latency.
REQ-025 rd_valid SHALL equal the previous cycle's (rd_en AND done).
REQ-026 rd_key SHALL update only when rd_en AND done, and otherwise hold its value.
REQ-027 A read and a re-key handshake in the same cycle SHALL return the old key set.
REQ-028 The round counter SHALL be 5 bits, with value 31 as the last XOR value; wrap-around SHALL NOT occur in operation.

Reset
REQ-029 When rst_n = 0 at a clock edge, the FSM SHALL enter IDLE, with i = 0, k = 0, done = 0, rd_valid = 0, and rd_key = 0.
REQ-030 Reset SHALL NOT clear round-key storage, whose contents are unreadable until done.
REQ-031 Reset asserted mid-EXPAND SHALL abort the expansion; a fresh handshake is then required.

Structure
REQ-032 A shared package present_pkg SHALL hold the KEY_SIZE, RK_SIZE, and NUM_ROUNDS constants, the 16-entry SBOX table (C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2), and the FSM state typedef.
REQ-033 The single-round key update SHALL be a combinational sub-module, present_key_round (inputs k and i, output next k), reusable by the encrypt/decrypt datapath.
REQ-034 Storage SHALL be a 32 x 64 register array with one write port and one registered read port.

Verification
REQ-035 Zero-key vectors: key_in = 0 with a handshake, wait for done, read idx 0/1/2 -> rd_key = 0000000000000000, C000000000000000, 5000180000000001.
REQ-036 done timing: handshake at cycle T -> done = 0 through T+31 and 1 at T+32; key_ready = 0 over the same window.
REQ-037 Read gating: rd_en with done = 0 -> rd_valid = 0 and rd_key unchanged; rd_en with done = 1 -> rd_valid = 1 the next cycle.
REQ-038 Key_valid ignored: key_valid pulsed at T+10 during EXPAND -> ignored; done at T+32 with the original key's schedule.
REQ-039 Re-key: handshake in READY -> done = 0 the next cycle, and the new K1 = new key_in[79:16] is readable at index 0 after the new done.
REQ-040 Mid-expansion reset: rst_n = 0 at T+15 -> IDLE, done = 0, rd_key = 0, key_ready = 1 the next cycle.
